dmi_jtag_access_ctrl: RTL

DMI_JTAG_ACCESS_CTRL -- requirements
Module: dmi_jtag_access_ctrl

---
 rtl/dmi_jtag_access_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmi_jtag_access_ctrl.sv
// DMI access controller for a RISC-V JTAG DTM: serial DR shift register, request/response
// handshake FSM toward the debug module, and sticky dmistat error tracking.
module dmi_jtag_access_ctrl #(
    parameter int unsigned AddrWidth = 7
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_reset_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned ShiftWidth = AddrWidth + 34;
    localparam logic [1:0] OpRead     = 2'd1;
    localparam logic [1:0] OpWrite    = 2'd2;
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrFailed  = 2'd2;
    localparam logic [1:0] ErrBusy    = 2'd3;
    localparam logic [1:0] RespFailed = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_READ,
        ST_WRITE,
        ST_WAIT_WRITE
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ShiftWidth-1:0]  r_shift;
    logic [AddrWidth-1:0]   r_addr;
    logic [31:0]            r_data;
    logic [1:0]             r_error;

    logic                   w_busy;
    logic                   w_latch;
    logic                   w_load_resp;
    logic [1:0]             w_err_set;
    logic [1:0]             w_status;
    logic [1:0]             w_shift_op;
    logic [31:0]            w_shift_data;
    logic [AddrWidth-1:0]   w_shift_addr;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_status     = w_busy ? ErrBusy : r_error;
    assign w_shift_op   = r_shift[1:0];
    assign w_shift_data = r_shift[33:2];
    assign w_shift_addr = r_shift[ShiftWidth-1:34];

    // Next state, latch/load strobes and candidate error; a failed response outranks busy.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_load_resp  = 1'b0;
        w_err_set    = ErrNone;
        if (w_busy && dmi_access_i && (capture_dr_i || update_dr_i)) begin
            w_err_set = ErrBusy;
        end
        unique case (r_state)
            ST_IDLE: begin
                if (dmi_access_i && update_dr_i && (r_error == ErrNone)) begin
                    if (w_shift_op == OpRead) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_READ;
                    end else if (w_shift_op == OpWrite) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (dmi_req_ready_i) w_state_next = ST_WAIT_READ;
            end
            ST_WRITE: begin
                if (dmi_req_ready_i) w_state_next = ST_WAIT_WRITE;
            end
            ST_WAIT_READ: begin
                if (dmi_resp_valid_i) begin
                    w_load_resp  = 1'b1;
                    w_state_next = ST_IDLE;
                    if (dmi_resp_resp_i == RespFailed) w_err_set = ErrFailed;
                end
            end
            ST_WAIT_WRITE: begin
                if (dmi_resp_valid_i) begin
                    w_state_next = ST_IDLE;
                    if (dmi_resp_resp_i == RespFailed) w_err_set = ErrFailed;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM, request payload and sticky error; error clears win over same-cycle sets.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_error <= ErrNone;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_addr <= w_shift_addr;
                r_data <= w_shift_data;
            end else if (w_load_resp) begin
                r_data <= dmi_resp_data_i;
            end
            if (dmi_reset_i || test_logic_reset_i) begin
                r_error <= ErrNone;
            end else if (r_error == ErrNone) begin
                r_error <= w_err_set;
            end
        end
    end

    // DR shift register: capture snapshot, LSB-first shift.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_shift <= '0;
        end else if (test_logic_reset_i) begin
            r_shift <= '0;
        end else if (dmi_access_i && capture_dr_i) begin
            r_shift <= {r_addr, r_data, w_status};
        end else if (dmi_access_i && shift_dr_i) begin
            r_shift <= {dmi_tdi_i, r_shift[ShiftWidth-1:1]};
        end
    end

    assign dmi_tdo_o        = r_shift[0];
    assign dmi_error_o      = r_error;
    assign dmi_req_valid_o  = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_data_o   = r_data;
    assign dmi_req_op_o     = (r_state == ST_WRITE) ? OpWrite : OpRead;
    assign dmi_resp_ready_o = (r_state == ST_WAIT_READ) || (r_state == ST_WAIT_WRITE);

endmodule
